// File: rtl/exec_unit.sv
// Execute/writeback stage: one ALU or shift-add multiply per start, written back to the register bank.
// Optional EXEC_UNIT_EARLY_MUL_EN: multiply ends as soon as the remaining multiplier is zero.
module exec_unit #(
    parameter int WIDTH  = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic              reg_write_en,
    output logic              busy,
    output logic              result_valid,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              overflow,
    output logic              illegal,
    output logic              write,
    output logic [REG_AW-1:0] write_register,
    output logic [WIDTH-1:0]  write_data
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t              state;
    logic [3:0]          op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [REG_AW-1:0]   dest_q;
    logic                wen_q;
    logic                fin;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    res_q;
    logic                ovf_q;
    logic                ill_q;

    logic [WIDTH-1:0]    sum;
    logic [WIDTH-1:0]    diff;
    logic [WIDTH-1:0]    alu_res;
    logic                alu_ovf;
    logic                alu_ill;
    logic [WIDTH-1:0]    mul_acc;
    logic                mul_done;
    logic                mul_early;
    logic                wb_go;
    logic [WIDTH-1:0]    wb_res;
    logic                wb_ovf;
    logic                wb_ill;

`ifndef EXEC_UNIT_EARLY_MUL_EN
    localparam int CNT_W = SH_W + 1;
    logic [CNT_W-1:0]    cnt;
`endif

    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op_q)
            4'd0: alu_res = a_q & b_q;
            4'd1: alu_res = a_q | b_q;
            4'd2: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd3: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd4: alu_res = a_q << b_q[SH_W-1:0];
            4'd5: alu_res = a_q >> b_q[SH_W-1:0];
            4'd7: alu_res = b_q;
            default: alu_ill = 1'b1;
        endcase
    end

    // In MUL, a_q/b_q are reused as the shifting multiplicand/multiplier.
    always_comb begin
        mul_acc = acc + (b_q[0] ? a_q : '0);
`ifdef EXEC_UNIT_EARLY_MUL_EN
        mul_early = ((b_q >> 1) == '0);
        mul_done  = 1'b0;
`else
        mul_early = 1'b0;
        mul_done  = (cnt == CNT_W'(WIDTH - 1));
`endif
        wb_go  = fin || ((state == MUL) && mul_early);
        wb_res = fin ? res_q : mul_acc;
        wb_ovf = fin ? ovf_q : 1'b0;
        wb_ill = fin ? ill_q : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            dest_q         <= '0;
            wen_q          <= 1'b0;
            fin            <= 1'b0;
            acc            <= '0;
            res_q          <= '0;
            ovf_q          <= 1'b0;
            ill_q          <= 1'b0;
`ifndef EXEC_UNIT_EARLY_MUL_EN
            cnt            <= '0;
`endif
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result         <= '0;
            zero           <= 1'b0;
            overflow       <= 1'b0;
            illegal        <= 1'b0;
            write          <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= opcode;
                        a_q    <= operand_a;
                        b_q    <= operand_b;
                        dest_q <= dest_reg;
                        wen_q  <= reg_write_en;
                        fin    <= 1'b0;
                        acc    <= '0;
`ifndef EXEC_UNIT_EARLY_MUL_EN
                        cnt    <= '0;
`endif
                        busy   <= 1'b1;
                        state  <= (opcode == 4'd6) ? MUL : EXEC;
                    end
                end
                EXEC, MUL: begin
                    if (wb_go) begin
                        // write_data/write_register change only here so the bank sees them stable.
                        result         <= wb_res;
                        zero           <= (wb_res == '0);
                        overflow       <= wb_ovf;
                        illegal        <= wb_ill;
                        result_valid   <= 1'b1;
                        write          <= wen_q & ~wb_ill;
                        write_register <= dest_q;
                        write_data     <= wb_res;
                        state          <= WB;
                    end else if (state == EXEC) begin
                        res_q <= alu_res;
                        ovf_q <= alu_ovf;
                        ill_q <= alu_ill;
                        fin   <= 1'b1;
                    end else begin
                        acc <= mul_acc;
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
`ifndef EXEC_UNIT_EARLY_MUL_EN
                        cnt <= cnt + 1'b1;
`endif
                        if (mul_done) begin
                            res_q <= mul_acc;
                            ovf_q <= 1'b0;
                            ill_q <= 1'b0;
                            fin   <= 1'b1;
                        end
                    end
                end
                WB: begin
                    result_valid <= 1'b0;
                    write        <= 1'b0;
                    illegal      <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute/writeback stage directly downstream of the 32x64 register bank.
- Takes read_data1/read_data2 as operand_a/operand_b, runs one ALU or multi-cycle multiply operation, and drives write/write_register/write_data back into the bank's write port.
- Single-issue; one operation in flight; start/busy handshake toward the decode/control logic.

Parameters:
- WIDTH, 64, datapath width; matches the register bank word.
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; accepted only when busy=0.
- opcode  input  4  operation select (see Behaviour).
- operand_a  input  WIDTH  first operand (from read_data1).
- operand_b  input  WIDTH  second operand / shift amount / multiplier (from read_data2).
- dest_reg  input  REG_AW  destination register.
- reg_write_en  input  1  1 = the result is written back.
- busy  output  1  high from acceptance until the writeback cycle ends.
- result_valid  output  1  one-cycle pulse in the writeback cycle.
- result  output  WIDTH  last result; held until the next result.
- zero  output  1  result==0; updated with result.
- overflow  output  1  signed overflow of ADD/SUB; 0 for other ops.
- illegal  output  1  one-cycle pulse in the writeback cycle for an undefined opcode.
- write  output  1  register-bank write enable.
- write_register  output  REG_AW  register-bank write address.
- write_data  output  WIDTH  register-bank write data.

Behaviour:
- Reset (rst_n=0, async, immediate): state=IDLE; busy, result_valid, write, illegal, zero, overflow = 0; result, write_data, write_register = 0.
- Opcodes:
  - 0 AND, 1 ORR, 2 ADD, 3 SUB (a-b), 7 PASSB (result=b).
  - 4 LSL: a << b[5:0]. 5 LSR: logical a >> b[5:0]. b[63:6] are ignored.
  - 6 MUL: low WIDTH bits of a*b, radix-2 shift-add.
  - 8..15 illegal: result=0, illegal pulse, write suppressed.
- ADD/SUB wrap modulo 2^WIDTH. overflow = signed overflow of that operation.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE: at the edge where start=1, latch opcode, a, b, dest_reg, reg_write_en. Call this edge E0. Go to MUL if opcode=6, else EXEC. busy=1 from E0.
  - EXEC: at E1, compute result, zero, overflow; go to WB.
  - MUL: each edge, if multiplier bit0=1 then acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1. After WIDTH iterations (E1..E64), load result and go to WB.
  - WB: lasts exactly one cycle. result_valid=1, write=reg_write_en and not illegal, write_register=latched dest, write_data=result. Next edge returns to IDLE and busy=0.
- Latency, start at E0:
  - ALU ops: WB is the cycle after E2; busy falls at E3.
  - MUL: WB is the cycle after E65; busy falls at E66.
- start while busy=1 is ignored; there is no queue. start in the WB cycle is also ignored. Earliest back-to-back acceptance is the edge ending WB+1, i.e. IDLE.
- Register-bank write timing:
  - write_data and write_register stay stable after WB until the next WB. Only write drops.
  - This is required because the bank commits write_data a delay after the sampling edge.
- Operands must be stable at E0; the bank's read path delay is absorbed by the control logic before asserting start.
- reg_write_en=0: full operation, result_valid pulses, write stays 0.
- Reset during EXEC/MUL/WB aborts the operation; no write occurs. A partially asserted write is cleared asynchronously.

Optional Feature:
- Macro EXEC_UNIT_EARLY_MUL_EN.
- Defined: MUL leaves for WB at the first edge after which the remaining multiplier is 0. Latency is data-dependent: WB starts after edge E(k+1), where k = index of the highest set bit of b, plus 1. For b=0, WB starts after E1.
- Undefined: fixed WIDTH iterations as above.
- Result values are identical in both cases.

Test Plan:
- ADD a=5, b=7, dest=3, wen=1 -> in WB: write=1, write_register=3, write_data=12, zero=0. busy high E0..E3.
- SUB a=7, b=7 -> result 0, zero=1. ADD a=0x7FFFFFFFFFFFFFFF, b=1 -> 0x8000000000000000, overflow=1.
- MUL a=3, b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFD with WB after E65 (macro off). MUL a=6, b=2 with macro -> 12 with WB after E2.
- start pulsed at E1 during ADD -> ignored, one WB only. Op with wen=0 -> result_valid=1, write=0.
- rst_n low during MUL iteration 30 -> busy=0, write=0 immediately, no WB. Next ADD 1+1 -> write_data=2.
- LSL a=1, b=0x43 -> 8. opcode 9 -> illegal=1, write=0, result=0.
